// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the 32/38 even-parity Hamming encoder and corrector.
// Codeword bit index = position-1; parity sits at the power-of-two positions.
package hamming_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAR_W  = 6;
  localparam int unsigned CW_W   = DATA_W + PAR_W;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned POS_W  = 6;

  localparam logic [POS_W-1:0] INJ_POS_MAX = POS_W'(CW_W);

  // Codeword indices of the parity bits (positions 1,2,4,8,16,32).
  localparam int unsigned PAR_IDX [PAR_W] = '{0, 1, 3, 7, 15, 31};

  // Codeword index of data bit k: the k-th non-power-of-two position, minus one.
  function automatic int unsigned data_to_pos(int unsigned k);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 0;
    for (int unsigned p = 1; p <= CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) res = p - 1;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_encoder_pipe_if.sv
// Upstream/downstream valid-ready bundle of the Hamming encoder pipe, with the injection hook.
interface hamming_encoder_pipe_if;
  import hamming_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              inj_en;
  logic [POS_W-1:0]  inj_pos;
  logic              out_valid;
  logic              out_ready;
  logic [CW_W-1:0]   out_cw;

  modport master (
    output in_valid, in_data, inj_en, inj_pos, out_ready,
    input  in_ready, out_valid, out_cw
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_pos, out_ready,
    output in_ready, out_valid, out_cw
  );

endinterface

// File: rtl/hamming_parity_gen.sv
// Combinational data placement plus even-parity generation: 32-bit word -> 38-bit codeword.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CW_W-1:0]   cw_o
);

  logic [CW_W-1:0]  placed;
  logic [PAR_W-1:0] par;

  always_comb begin
    placed = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      placed[6'(data_to_pos(k))] = data_i[5'(k)];
    end
  end

  // Parity positions are zero in placed, so covering them changes nothing.
  always_comb begin
    par = '0;
    for (int unsigned i = 0; i < PAR_W; i++) begin
      for (int unsigned j = 1; j <= CW_W; j++) begin
        if ((j & (32'd1 << i)) != 0) par[i] = par[i] ^ placed[6'(j - 1)];
      end
    end
  end

  always_comb begin
    cw_o = placed;
    for (int unsigned i = 0; i < PAR_W; i++) begin
      cw_o[6'(PAR_IDX[i])] = par[i];
    end
  end

endmodule

// File: rtl/hamming_encoder_pipe.sv
// Two-stage valid/ready Hamming encoder with per-word single-bit error injection and counters.
module hamming_encoder_pipe
  import hamming_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  hamming_encoder_pipe_if.slave bus,
  output logic [CNT_W-1:0]    cw_count,
  output logic [CNT_W-1:0]    inj_count
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_inj_en_q, s1_inj_en_d;
  logic [POS_W-1:0]  s1_inj_pos_q, s1_inj_pos_d;
  logic              out_valid_q, out_valid_d;
  logic [CW_W-1:0]   out_cw_q, out_cw_d;
  logic              flip_q, flip_d;
  logic [CNT_W-1:0]  cw_count_q, cw_count_d;
  logic [CNT_W-1:0]  inj_count_q, inj_count_d;

  logic            in_ready;
  logic            in_hs;
  logic            out_hs;
  logic            s2_load;
  logic            flip;
  logic [CW_W-1:0] enc_cw;
  logic [CW_W-1:0] inj_mask;

  hamming_parity_gen u_parity_gen (
    .data_i (s1_data_q),
    .cw_o   (enc_cw)
  );

  assign in_ready = !s1_valid_q || !out_valid_q || bus.out_ready;
  assign in_hs    = bus.in_valid && in_ready;
  assign out_hs   = out_valid_q && bus.out_ready;
  assign s2_load  = s1_valid_q && (!out_valid_q || bus.out_ready);

  assign flip     = s1_inj_en_q && (s1_inj_pos_q != '0) && (s1_inj_pos_q <= INJ_POS_MAX);
  assign inj_mask = flip ? (CW_W'(1) << (s1_inj_pos_q - 6'd1)) : '0;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_inj_en_d  = s1_inj_en_q;
    s1_inj_pos_d = s1_inj_pos_q;
    out_valid_d  = out_valid_q;
    out_cw_d     = out_cw_q;
    flip_d       = flip_q;
    cw_count_d   = cw_count_q;
    inj_count_d  = inj_count_q;

    if (in_hs) begin
      s1_valid_d   = 1'b1;
      s1_data_d    = bus.in_data;
      s1_inj_en_d  = bus.inj_en;
      s1_inj_pos_d = bus.inj_pos;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // A load wins over a drain so a same-cycle take-and-reload keeps out_valid high.
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_cw_d    = enc_cw ^ inj_mask;
      flip_d      = flip;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    if (out_hs) begin
      cw_count_d = cw_count_q + 1'b1;
      if (flip_q) inj_count_d = inj_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_inj_en_q  <= 1'b0;
      s1_inj_pos_q <= '0;
      out_valid_q  <= 1'b0;
      out_cw_q     <= '0;
      flip_q       <= 1'b0;
      cw_count_q   <= '0;
      inj_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_inj_en_q  <= s1_inj_en_d;
      s1_inj_pos_q <= s1_inj_pos_d;
      out_valid_q  <= out_valid_d;
      out_cw_q     <= out_cw_d;
      flip_q       <= flip_d;
      cw_count_q   <= cw_count_d;
      inj_count_q  <= inj_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cw    = out_cw_q;
  assign cw_count      = cw_count_q;
  assign inj_count     = inj_count_q;

endmodule

// File: tb/tb_hamming_encoder_pipe.sv
// Directed and scoreboarded checks of hamming_encoder_pipe against an independent syndrome model.
module tb_hamming_encoder_pipe;
  import hamming_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cw_count;
  logic [15:0] inj_count;
  int          total = 0;
  int          bad = 0;

  hamming_encoder_pipe_if bus ();

  hamming_encoder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cw_count  (cw_count),
    .inj_count (inj_count)
  );

  always #5 clk = ~clk;

  // Place data, then pick parity bits equal to the syndrome of the data-only word.
  function automatic logic [37:0] enc_model(input logic [31:0] d);
    logic [37:0] cw;
    logic [5:0]  syn;
    int          k;
    cw  = '0;
    syn = '0;
    k   = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 38; p++) if (cw[p-1]) syn = syn ^ 6'(p);
    for (int i = 0; i < 6; i++) cw[(1 << i) - 1] = syn[i];
    return cw;
  endfunction

  function automatic logic [37:0] correct(input logic [37:0] cw);
    logic [5:0]  syn;
    logic [37:0] r;
    syn = '0;
    r   = cw;
    for (int p = 1; p <= 38; p++) if (cw[p-1]) syn = syn ^ 6'(p);
    if (syn >= 6'd1 && syn <= 6'd38) r[syn-1] = ~r[syn-1];
    return r;
  endfunction

  task automatic send_one(input logic [31:0] d, input logic en, input logic [5:0] pos,
                          output logic [37:0] cw, output int lat);
    cw  = '0;
    lat = 99;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.inj_en    = en;
    bus.inj_pos   = pos;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.inj_en   = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        cw  = bus.out_cw;
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    total++;
    if (bus.out_cw !== 38'h0) begin
      bad++; $display("FAIL reset_out_cw got=%h want=0", bus.out_cw);
    end
    total++;
    if (cw_count !== 16'd0 || inj_count !== 16'd0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", cw_count, inj_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [37:0] cw;
    int          lat;
    send_one(32'h0000_0001, 1'b0, 6'd0, cw, lat);
    total++;
    if (cw !== 38'h00_0000_0007) begin
      bad++; $display("FAIL basic_one got=%h want=%h", cw, 38'h00_0000_0007);
    end
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL basic_latency got=%0d want=2", lat);
    end
    send_one(32'h0000_0002, 1'b0, 6'd0, cw, lat);
    total++;
    if (cw !== 38'h00_0000_0019) begin
      bad++; $display("FAIL basic_two got=%h want=%h", cw, 38'h00_0000_0019);
    end
    send_one(32'hFFFF_FFFF, 1'b0, 6'd0, cw, lat);
    total++;
    if (cw !== 38'h3F_7FFF_FFF4) begin
      bad++; $display("FAIL basic_ones got=%h want=%h", cw, 38'h3F_7FFF_FFF4);
    end
    total++;
    if (cw_count !== 16'd3 || inj_count !== 16'd0) begin
      bad++; $display("FAIL basic_counts got=%0d/%0d want=3/0", cw_count, inj_count);
    end
  endtask

  task automatic test_inject();
    logic [37:0] cw;
    int          lat;
    send_one(32'hFFFF_FFFF, 1'b1, 6'd5, cw, lat);
    total++;
    if (cw !== 38'h3F_7FFF_FFE4) begin
      bad++; $display("FAIL inject_pos5 got=%h want=%h", cw, 38'h3F_7FFF_FFE4);
    end
    total++;
    if (correct(cw) !== 38'h3F_7FFF_FFF4) begin
      bad++; $display("FAIL inject_corrected got=%h want=%h", correct(cw), 38'h3F_7FFF_FFF4);
    end
    total++;
    if (inj_count !== 16'd1) begin
      bad++; $display("FAIL inject_count got=%0d want=1", inj_count);
    end
  endtask

  task automatic test_inj_range();
    logic [37:0] cw;
    int          lat;
    send_one(32'hFFFF_FFFF, 1'b1, 6'd0, cw, lat);
    total++;
    if (cw !== 38'h3F_7FFF_FFF4) begin
      bad++; $display("FAIL range_pos0 got=%h want=%h", cw, 38'h3F_7FFF_FFF4);
    end
    send_one(32'hFFFF_FFFF, 1'b1, 6'd39, cw, lat);
    total++;
    if (cw !== 38'h3F_7FFF_FFF4) begin
      bad++; $display("FAIL range_pos39 got=%h want=%h", cw, 38'h3F_7FFF_FFF4);
    end
    total++;
    if (inj_count !== 16'd1) begin
      bad++; $display("FAIL range_count_unchanged got=%0d want=1", inj_count);
    end
    send_one(32'hFFFF_FFFF, 1'b1, 6'd1, cw, lat);
    total++;
    if (cw !== 38'h3F_7FFF_FFF5) begin
      bad++; $display("FAIL range_pos1 got=%h want=%h", cw, 38'h3F_7FFF_FFF5);
    end
    send_one(32'hFFFF_FFFF, 1'b1, 6'd38, cw, lat);
    total++;
    if (cw !== 38'h1F_7FFF_FFF4) begin
      bad++; $display("FAIL range_pos38 got=%h want=%h", cw, 38'h1F_7FFF_FFF4);
    end
    send_one(32'hFFFF_FFFF, 1'b0, 6'd5, cw, lat);
    total++;
    if (cw !== 38'h3F_7FFF_FFF4) begin
      bad++; $display("FAIL range_not_sticky got=%h want=%h", cw, 38'h3F_7FFF_FFF4);
    end
    total++;
    if (inj_count !== 16'd3 || cw_count !== 16'd9) begin
      bad++; $display("FAIL range_counts got=%0d/%0d want=9/3", cw_count, inj_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [8];
    logic [37:0] cw;
    logic        rdy, ov;
    logic [15:0] start_cnt;
    int          sent, recv;
    bit          saw_stall;
    sent      = 0;
    recv      = 0;
    saw_stall = 1'b0;
    start_cnt = cw_count;
    for (int i = 0; i < 8; i++) words[i] = 32'hA5A5_0000 + 32'(i) * 32'h0101_0137;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      bus.in_valid  = (sent < 8);
      bus.in_data   = words[sent < 8 ? sent : 7];
      #1;
      rdy = bus.in_ready;
      ov  = bus.out_valid;
      cw  = bus.out_cw;
      if (!rdy) begin
        saw_stall = 1'b1;
        total++;
        if (sent - recv != 2) begin
          bad++; $display("FAIL bp_stall_depth got=%0d want=2", sent - recv);
        end
      end
      @(posedge clk);
      if (bus.in_valid && rdy) sent++;
      if (ov && bus.out_ready) begin
        total++;
        if (recv >= 8 || cw !== enc_model(words[recv < 8 ? recv : 7])) begin
          bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", recv, cw,
                          enc_model(words[recv < 8 ? recv : 7]));
        end
        recv++;
      end
    end
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    total++;
    if (!saw_stall) begin
      bad++; $display("FAIL bp_in_ready_drop got=never want=low");
    end
    total++;
    if (recv !== 8) begin
      bad++; $display("FAIL bp_received got=%0d want=8", recv);
    end
    total++;
    if (cw_count !== 16'(start_cnt + 16'd8)) begin
      bad++; $display("FAIL bp_cw_count got=%0d want=%0d", cw_count, start_cnt + 16'd8);
    end
  endtask

  task automatic test_reset_mid();
    logic [37:0] cw;
    int          lat;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_0001;
    @(negedge clk);
    bus.in_data = 32'h0000_0002;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_full got=%b/%b want=1/0", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_cw !== 38'h0) begin
      bad++; $display("FAIL rstmid_out got=%b/%h want=0/0", bus.out_valid, bus.out_cw);
    end
    total++;
    if (cw_count !== 16'd0 || inj_count !== 16'd0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_state got=%0d/%0d/%b want=0/0/1", cw_count, inj_count,
                      bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_one(32'h0000_0002, 1'b0, 6'd0, cw, lat);
    total++;
    if (cw !== 38'h00_0000_0019 || lat !== 2) begin
      bad++; $display("FAIL rstmid_next got=%h lat=%0d want=%h lat=2", cw, lat, 38'h19);
    end
    total++;
    if (cw_count !== 16'd1) begin
      bad++; $display("FAIL rstmid_count got=%0d want=1", cw_count);
    end
  endtask

  task automatic test_random();
    logic [37:0] expq [$];
    logic [37:0] modq [$];
    logic [37:0] cw, m, e;
    logic        rdy, ov, acc, f;
    logic [15:0] start_cw, exp_inj;
    int          sent, recv;
    sent     = 0;
    recv     = 0;
    acc      = 1'b0;
    start_cw = cw_count;
    exp_inj  = inj_count;
    for (int cyc = 0; cyc < 8000 && recv < 1000; cyc++) begin
      @(negedge clk);
      if (acc) bus.in_valid = 1'b0;
      acc = 1'b0;
      bus.out_ready = ($urandom_range(3) != 0);
      if (!bus.in_valid && sent < 1000) begin
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        bus.inj_en   = ($urandom_range(1) == 1);
        bus.inj_pos  = 6'($urandom_range(45));
      end
      #1;
      rdy = bus.in_ready;
      ov  = bus.out_valid;
      cw  = bus.out_cw;
      @(posedge clk);
      if (bus.in_valid && rdy) begin
        m = enc_model(bus.in_data);
        f = bus.inj_en && bus.inj_pos >= 6'd1 && bus.inj_pos <= 6'd38;
        e = f ? (m ^ (38'd1 << (bus.inj_pos - 6'd1))) : m;
        expq.push_back(e);
        modq.push_back(m);
        if (f) exp_inj = exp_inj + 16'd1;
        sent++;
        acc = 1'b1;
      end
      if (ov && bus.out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL rand_extra got=%h want=none", cw);
        end else begin
          e = expq.pop_front();
          m = modq.pop_front();
          if (cw !== e) begin
            bad++; $display("FAIL rand_cw idx=%0d got=%h want=%h", recv, cw, e);
          end
          total++;
          if (correct(cw) !== m) begin
            bad++; $display("FAIL rand_corrected idx=%0d got=%h want=%h", recv, correct(cw), m);
          end
        end
        recv++;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    total++;
    if (recv !== 1000) begin
      bad++; $display("FAIL rand_received got=%0d want=1000", recv);
    end
    total++;
    if (cw_count !== 16'(start_cw + 16'd1000)) begin
      bad++; $display("FAIL rand_cw_count got=%0d want=%0d", cw_count, start_cw + 16'd1000);
    end
    total++;
    if (inj_count !== exp_inj) begin
      bad++; $display("FAIL rand_inj_count got=%0d want=%0d", inj_count, exp_inj);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.inj_en    = 1'b0;
    bus.inj_pos   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_inject();
    test_inj_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
